// File: rtl/data_mem_responder.sv
// Data-port responder: 240-byte RAM, button event capture, display FIFO.
// Ports: CLK/RESET, CPU ADDR/WDATA/MW/RD/DIN, BTN_IN, DISP_VALID/DATA/READY.
module data_mem_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int BTN_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       ADDR,
  input  logic [7:0]       WDATA,
  input  logic             MW,
  input  logic             RD,
  output logic [7:0]       DIN,
  input  logic [BTN_W-1:0] BTN_IN,
  output logic             DISP_VALID,
  output logic [7:0]       DISP_DATA,
  input  logic             DISP_READY
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [7:0] RAM_TOP = 8'hF0;
  localparam logic [7:0] A_STATUS = 8'hF0;
  localparam logic [7:0] A_BTN = 8'hF1;
  localparam logic [7:0] A_PUSH = 8'hF2;
  localparam logic [7:0] A_DROP = 8'hF3;

  logic [7:0] ram [0:239];
  logic [7:0] fifo [0:FIFO_DEPTH-1];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [BTN_W-1:0] btn_prev;
  logic [BTN_W-1:0] mask;
  logic [BTN_W-1:0] rise;
  logic pending;
  logic [7:0] drop_cnt;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic fifo_wr;
  logic drop;
  logic btn_rd;
  logic ram_wr;
  logic [7:0] mask_ext;
  logic [7:0] status;

  assign ram_wr = MW & (ADDR < RAM_TOP);
  assign empty = (count == '0);
  assign full = (count == FULL_CNT);
  assign push = MW & (ADDR == A_PUSH);
  assign pop = ~empty & DISP_READY;
  // A pop in the same cycle frees the slot a full push needs.
  assign fifo_wr = push & (~full | pop);
  assign drop = push & full & ~pop;
  assign btn_rd = RD & (ADDR == A_BTN);
  assign rise = BTN_IN & ~btn_prev;

  assign DISP_VALID = ~empty;
  assign DISP_DATA = fifo[rd_ptr];

  always_comb begin
    mask_ext = '0;
    mask_ext[BTN_W-1:0] = mask;
  end

  assign status = {5'b0, pending, empty, full};

  always_comb begin
    DIN = '0;
    unique case (1'b1)
      (ADDR < RAM_TOP):    DIN = ram[ADDR];
      (ADDR == A_STATUS):  DIN = status;
      (ADDR == A_BTN):     DIN = mask_ext;
      (ADDR == A_DROP):    DIN = drop_cnt;
      default:             DIN = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (ram_wr) ram[ADDR] <= WDATA;
  end

  always_ff @(posedge CLK) begin
    if (fifo_wr) fifo[wr_ptr] <= WDATA;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({fifo_wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drop_cnt <= '0;
    end else if (MW & (ADDR == A_DROP)) begin
      drop_cnt <= '0;
    end else if (drop & (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // A read-clear keeps any edge arriving in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btn_prev <= '0;
      mask <= '0;
      pending <= 1'b0;
    end else begin
      btn_prev <= BTN_IN;
      if (btn_rd) begin
        mask <= rise;
        pending <= |rise;
      end else if (|rise) begin
        mask <= mask | rise;
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder.
// Queue-based reference model; monitor checks display transfers.
module tb_data_mem_responder;
  localparam int D = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [7:0] ADDR = '0;
  logic [7:0] WDATA = '0;
  logic MW = 1'b0;
  logic RD = 1'b0;
  logic [7:0] DIN;
  logic [3:0] BTN_IN = '0;
  logic DISP_VALID;
  logic [7:0] DISP_DATA;
  logic DISP_READY = 1'b0;

  data_mem_responder #(.FIFO_DEPTH(D), .BTN_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WDATA(WDATA),
    .MW(MW), .RD(RD), .DIN(DIN), .BTN_IN(BTN_IN),
    .DISP_VALID(DISP_VALID), .DISP_DATA(DISP_DATA),
    .DISP_READY(DISP_READY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;

  logic [7:0] ram_m [0:239];
  bit ram_ok [0:239];
  logic [3:0] bprev_m = '0;
  logic [3:0] mask_m = '0;
  bit pend_m = 0;
  int drop_m = 0;
  logic [7:0] mq [$];
  logic [7:0] sb_q [$];

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", n, act, exp);
  endtask

  function automatic int exp_din(input int a, output bit known);
    known = 1;
    if (a < 240) begin
      known = ram_ok[a];
      return int'(ram_m[a]);
    end
    case (a)
      240: return (int'(pend_m) << 2) | (int'(mq.size() == 0) << 1)
                  | int'(mq.size() == D);
      241: return int'(mask_m);
      243: return drop_m;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    mq.delete();
    sb_q.delete();
    bprev_m = '0;
    mask_m = '0;
    pend_m = 0;
    drop_m = 0;
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] wd,
                      input bit mw, input bit rd,
                      input logic [3:0] btn, input bit rdy);
    bit known;
    int e;
    bit popm;
    logic [3:0] rise;
    int sz;
    ADDR = a;
    WDATA = wd;
    MW = mw;
    RD = rd;
    BTN_IN = btn;
    DISP_READY = rdy;
    #1;
    e = exp_din(int'(a), known);
    if (known) chk($sformatf("din@%02h", a), int'(DIN), e);
    chk("disp_valid", int'(DISP_VALID), int'(mq.size() != 0));
    if (mq.size() != 0) chk("disp_head", int'(DISP_DATA), int'(mq[0]));
    // next-state of the reference model
    if (mw && a < 8'hF0) begin
      ram_m[a] = wd;
      ram_ok[a] = 1;
    end
    sz = mq.size();
    popm = (sz != 0) && rdy;
    if (popm) void'(mq.pop_front());
    if (mw && a == 8'hF2) begin
      if (sz < D || popm) begin
        mq.push_back(wd);
        sb_q.push_back(wd);
      end else if (drop_m < 255) begin
        drop_m++;
      end
    end
    if (mw && a == 8'hF3) drop_m = 0;
    rise = btn & ~bprev_m;
    if (rd && a == 8'hF1) begin
      mask_m = rise;
      pend_m = (rise != 0);
    end else if (rise != 0) begin
      mask_m = mask_m | rise;
      pend_m = 1;
    end
    bprev_m = btn;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    MW = 0;
    RD = 0;
    BTN_IN = '0;
    DISP_READY = 0;
    #1;
    RESET = 1;
    model_clear();
    #1;
    chk("rst_valid", int'(DISP_VALID), 0);
    ADDR = 8'hF0;
    #1;
    chk("rst_status", int'(DIN), 2);
    ADDR = 8'hF3;
    #1;
    chk("rst_drop", int'(DIN), 0);
    @(posedge CLK);
    #1;
    RESET = 0;
  endtask

  always @(negedge CLK) begin
    if (!RESET && DISP_VALID && DISP_READY) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL disp_pop actual=0x%0h required=none", DISP_DATA);
      end else begin
        chk("disp_pop", int'(DISP_DATA), int'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] a;
    logic [3:0] btn;
    @(posedge CLK);
    #1;
    chk("init_valid", int'(DISP_VALID), 0);
    @(posedge CLK);
    #1;
    RESET = 0;
    // RAM write/read, unmapped write
    step(8'h10, 8'h5A, 1, 0, 4'h0, 0);
    step(8'h10, 8'h00, 0, 1, 4'h0, 0);
    step(8'hF4, 8'h77, 1, 0, 4'h0, 0);
    step(8'hF4, 8'h00, 0, 1, 4'h0, 0);
    step(8'hF2, 8'h00, 0, 1, 4'h0, 0);
    // button capture and read-clear
    step(8'hF0, 8'h00, 0, 0, 4'h4, 0);
    ADDR = 8'hF0;
    #1;
    chk("t2_status", int'(DIN), 8'h06);
    step(8'hF1, 8'h00, 0, 1, 4'h4, 0);
    step(8'hF0, 8'h00, 0, 0, 4'h4, 0);
    step(8'hF1, 8'h00, 0, 1, 4'h4, 0);
    // read-clear concurrent with new edge
    step(8'hF0, 8'h00, 0, 0, 4'h0, 0);
    step(8'hF0, 8'h00, 0, 0, 4'h4, 0);
    step(8'hF1, 8'h00, 0, 1, 4'h5, 0);
    ADDR = 8'hF1;
    #1;
    chk("t3_mask", int'(DIN), 8'h01);
    step(8'hF0, 8'h00, 0, 0, 4'h5, 0);
    step(8'hF1, 8'h00, 0, 1, 4'h5, 0);
    // overflow with display stalled
    step(8'hF2, 8'h11, 1, 0, 4'h0, 0);
    step(8'hF2, 8'h22, 1, 0, 4'h0, 0);
    step(8'hF2, 8'h33, 1, 0, 4'h0, 0);
    step(8'hF2, 8'h44, 1, 0, 4'h0, 0);
    step(8'hF2, 8'h55, 1, 0, 4'h0, 0);
    ADDR = 8'hF3;
    #1;
    chk("t4_drop", int'(DIN), 1);
    chk("t4_head", int'(DISP_DATA), 8'h11);
    step(8'hF0, 8'h00, 0, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++) step(8'hF3, 8'h00, 0, 0, 4'h0, 1);
    // push while full with a pop in the same cycle
    for (int i = 0; i < 4; i++) step(8'hF2, 8'(8'hA0 + i), 1, 0, 4'h0, 0);
    step(8'hF2, 8'h66, 1, 0, 4'h0, 1);
    step(8'hF3, 8'h00, 0, 1, 4'h0, 1);
    for (int i = 0; i < 4; i++) step(8'hF0, 8'h00, 0, 0, 4'h0, 1);
    step(8'hF3, 8'h99, 1, 0, 4'h0, 0);
    step(8'hF3, 8'h00, 0, 1, 4'h0, 0);
    // reset mid-drain
    step(8'hF2, 8'h01, 1, 0, 4'h0, 0);
    step(8'hF2, 8'h02, 1, 0, 4'h0, 0);
    step(8'hF2, 8'h03, 1, 0, 4'h0, 0);
    step(8'hF0, 8'h00, 0, 0, 4'h0, 1);
    do_reset();
    step(8'h10, 8'h00, 0, 1, 4'h0, 0);
    chk("t6_ram", int'(DIN), 8'h5A);
    // randomized traffic
    btn = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 4) a = 8'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) < 2) a = 8'($urandom_range(0, 239));
      else a = 8'(8'hF0 + $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) btn = 4'($urandom);
      if (i % 700 == 699) do_reset();
      else step(a, 8'($urandom), ($urandom_range(0, 2) == 0)
                || (a == 8'hF2 && $urandom_range(0, 1) == 0),
                $urandom_range(0, 1) == 1, btn,
                $urandom_range(0, 2) == 0);
    end
    step(8'h00, 8'h00, 0, 0, 4'h0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
